// File: rtl/bc_pkg.sv
// Shared digit-width, packing and LFSR constants for the bulls-and-cows datapath,
// plus the secret generator state encoding and the LFSR step function.
package bc_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_MAX  = 9;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } gen_state_e;

  // Right-shifting Galois step; the all-zero state would lock up, so it maps to 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur, input logic ent);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    nxt[0] = nxt[0] ^ ent;
    if (nxt == 16'h0000) begin
      nxt = 16'h0001;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/secret_gen_if.sv
// Request/result bundle between the game controller (master) and secret_gen (slave).
interface secret_gen_if;

  logic        new_game;
  logic        entropy;
  logic [15:0] answer;
  logic        answer_valid;
  logic        busy;

  modport master (
    output new_game,
    output entropy,
    input  answer,
    input  answer_valid,
    input  busy
  );

  modport slave (
    input  new_game,
    input  entropy,
    output answer,
    output answer_valid,
    output busy
  );

endinterface

// File: rtl/bc_lfsr16.sv
// Free-running 16-bit Galois LFSR with keypad entropy injection and zero-lock guard.
module bc_lfsr16
  import bc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entropy,
  output logic [3:0] rnd_nibble
);

  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q, entropy);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED_SAFE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_nibble = lfsr_q[3:0];

endmodule

// File: rtl/secret_gen.sv
// Draws four distinct BCD digits from bc_lfsr16, with a smallest-unused-digit fallback.
// Optional macro BC_NO_LEADING_ZERO_EN forbids 0 in the first-entered digit.
module secret_gen
  import bc_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_DRAWS = 64
) (
  input  logic            clk,
  input  logic            rst,
  secret_gen_if.slave     bus
);

  localparam int CNT_W = (MAX_DRAWS < 1) ? 1 : $clog2(MAX_DRAWS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DRAWS);
  localparam logic [3:0]       DMAX     = 4'(DIGIT_MAX);
  localparam logic [1:0]       LAST_SLOT = 2'(NUM_DIGITS - 1);

  gen_state_e        state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [CNT_W-1:0]  rej_cnt_q, rej_cnt_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [15:0]       answer_q, answer_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [3:0]        cand;
  logic [15:0]       used;
  logic [3:0]        fallback;
  logic              zero_banned;
  logic              cand_ok;
  logic              at_limit;
  logic              accept;
  logic [3:0]        digit;
  logic [15:0]       merged;

  bc_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .entropy    (bus.entropy),
    .rnd_nibble (cand)
  );

  // Digits already committed to earlier slots, and the smallest digit still free.
  always_comb begin
    used     = '0;
    fallback = 4'd0;
`ifdef BC_NO_LEADING_ZERO_EN
    zero_banned = (slot_q == 2'd0);
`else
    zero_banned = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i < int'(slot_q)) begin
        used[shadow_q[15-4*i -: 4]] = 1'b1;
      end
    end
    for (int d = DIGIT_MAX; d >= 0; d--) begin
      if (!used[d] && !(zero_banned && (d == 0))) begin
        fallback = 4'(d);
      end
    end
  end

  always_comb begin
    cand_ok  = (cand <= DMAX) && !used[cand] && !(zero_banned && (cand == 4'd0));
    at_limit = (rej_cnt_q == MAX_CNT);
    accept   = at_limit || cand_ok;
    digit    = at_limit ? fallback : cand;
    merged   = shadow_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(slot_q)) begin
        merged[15-4*i -: 4] = digit;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    rej_cnt_d = rej_cnt_q;
    shadow_d  = shadow_q;
    answer_d  = answer_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.new_game) begin
          state_d   = DRAW;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          slot_d    = 2'd0;
          rej_cnt_d = '0;
          shadow_d  = '0;
        end
      end
      DRAW: begin
        // new_game is deliberately not looked at here: a running draw is never restarted.
        if (accept) begin
          shadow_d  = merged;
          rej_cnt_d = '0;
          slot_d    = slot_q + 2'd1;
          if (slot_q == LAST_SLOT) begin
            answer_d = merged;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = DONE;
          end
        end else begin
          rej_cnt_d = rej_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      slot_q    <= 2'd0;
      rej_cnt_q <= '0;
      shadow_q  <= '0;
      answer_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      rej_cnt_q <= rej_cnt_d;
      shadow_q  <= shadow_d;
      answer_q  <= answer_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.answer       = answer_q;
  assign bus.answer_valid = valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_secret_gen.sv
// Self-checking bench for secret_gen: default build plus a MAX_DRAWS=0 instance,
// checked against a digit-drawing reference model that tracks the LFSR arithmetically.
module tb_secret_gen;

  localparam int MAXD   = 64;
  localparam int LIMIT  = 4 * (MAXD + 1) + 4;
  localparam int SEED_M = 'hACE1;
`ifdef BC_NO_LEADING_ZERO_EN
  localparam bit NLZ = 1'b1;
  localparam logic [15:0] EXP_FB = 16'h1023;
`else
  localparam bit NLZ = 1'b0;
  localparam logic [15:0] EXP_FB = 16'h0123;
`endif

  typedef struct {
    int          gap;
    bit          ent;
    logic [15:0] exp_ans;
    int          exp_lat;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   model_lfsr;
  logic [15:0] model_answer;
  bit   ent_seq [0:299];

  secret_gen_if bus ();
  secret_gen_if bus0 ();

  secret_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  secret_gen #(
    .MAX_DRAWS (0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step(input int l, input int e);
    int lsb;
    int r;
    lsb = l % 2;
    r   = l / 2;
    if (lsb == 1) r = r ^ 'hB400;
    r = r ^ e;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Model of the default instance's LFSR, advanced once per clock from its reset seed.
  always @(posedge clk or negedge rst) begin
    if (!rst) model_lfsr <= SEED_M;
    else      model_lfsr <= step(model_lfsr, int'(bus.entropy));
  end

  // Draw four distinct digits from a starting LFSR value; one decision consumes one clock.
  task automatic predict(input int l_in, output logic [15:0] ans, output int lat);
    int used[$];
    int l;
    int cand;
    int d;
    int rej;
    bit acc;
    bit seen;
    l   = l_in;
    ans = 16'h0000;
    lat = 0;
    for (int slot = 0; slot < 4; slot++) begin
      rej = 0;
      acc = 1'b0;
      d   = 0;
      while (!acc) begin
        cand = l % 16;
        if (rej == MAXD) begin
          for (int c = 9; c >= 0; c--) begin
            seen = 1'b0;
            foreach (used[j]) if (used[j] == c) seen = 1'b1;
            if (!seen && !(NLZ && slot == 0 && c == 0)) d = c;
          end
          acc = 1'b1;
        end else begin
          seen = 1'b0;
          foreach (used[j]) if (used[j] == cand) seen = 1'b1;
          if (cand <= 9 && !seen && !(NLZ && slot == 0 && cand == 0)) begin
            d   = cand;
            acc = 1'b1;
          end else begin
            rej++;
          end
        end
        l = step(l, int'(ent_seq[lat]));
        lat++;
      end
      used.push_back(d);
      ans = ans | 16'(d << (12 - 4 * slot));
    end
  endtask

  function automatic bit digits_ok(input logic [15:0] a);
    int n [4];
    for (int i = 0; i < 4; i++) begin
      n[i] = int'((a >> (4 * i)) & 16'h000F);
      if (n[i] > 9) return 1'b0;
    end
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (n[i] == n[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive the default instance's inputs and advance to the next falling edge.
  task automatic applyStimulus(input logic ng, input logic ent);
    bus.new_game = ng;
    bus.entropy  = ent;
    @(negedge clk);
  endtask

  // mode 0: single request; 1: extra request while busy; 2: extra request on the final accept.
  task automatic runGame(input int mode, input bit rnd_ent, output logic [15:0] exp_ans);
    int  l0;
    int  exp_lat;
    int  got_lat;
    bit  hold_ok;
    bit  done_ok;
    logic ng;
    applyStimulus(1'b1, 1'($urandom_range(1, 0)));
    l0 = model_lfsr;
    for (int i = 0; i < 300; i++) ent_seq[i] = rnd_ent ? 1'($urandom_range(1, 0)) : 1'b0;
    predict(l0, exp_ans, exp_lat);
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    checkOutput("valid_drop_on_start", 32'(bus.answer_valid), 32'd0);
    hold_ok = 1'b1;
    got_lat = 0;
    for (int k = 1; k <= LIMIT; k++) begin
      ng = ((mode == 1) && (k == 2)) || ((mode == 2) && (k == exp_lat));
      applyStimulus(ng, ent_seq[k-1]);
      if (bus.answer_valid) begin
        got_lat = k;
        break;
      end
      if (bus.answer !== model_answer) hold_ok = 1'b0;
    end
    checkOutput("latency", 32'(got_lat), 32'(exp_lat));
    checkOutput("answer", 32'(bus.answer), 32'(exp_ans));
    checkOutput("busy_at_valid", 32'(bus.busy), 32'd0);
    checkOutput("digits_distinct", 32'(digits_ok(bus.answer)), 32'd1);
    checkOutput("answer_held_during_draw", 32'(hold_ok), 32'd1);
    done_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0);
      if (!bus.answer_valid || bus.busy || bus.answer !== exp_ans) done_ok = 1'b0;
    end
    checkOutput("stays_done", 32'(done_ok), 32'd1);
    model_answer = exp_ans;
  endtask

  task automatic doReset();
    rst = 1'b0;
    model_answer = 16'h0000;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    vec_t        vecs [4];
    logic [15:0] ans_a;
    logic [15:0] ans_b;
    int          lat0;

    checks = 0;
    errors = 0;
    model_answer = 16'h0000;
    bus.new_game  = 1'b0;
    bus.entropy   = 1'b0;
    bus0.new_game = 1'b0;
    bus0.entropy  = 1'b0;
    rst = 1'b0;

    vecs[0] = '{gap: 0, ent: 1'b0, exp_ans: EXP_FB, exp_lat: 4};
    vecs[1] = '{gap: 3, ent: 1'b1, exp_ans: EXP_FB, exp_lat: 4};
    vecs[2] = '{gap: 7, ent: 1'b1, exp_ans: EXP_FB, exp_lat: 4};
    vecs[3] = '{gap: 1, ent: 1'b0, exp_ans: EXP_FB, exp_lat: 4};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_answer", 32'(bus.answer), 32'h0);
    checkOutput("reset_valid", 32'(bus.answer_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_release_answer", 32'(bus.answer), 32'h0);
    checkOutput("post_release_busy", 32'(bus.busy), 32'd0);
    checkOutput("fb_reset_valid", 32'(bus0.answer_valid), 32'd0);

    // MAX_DRAWS=0 instance: every slot takes the fallback digit.
    for (int v = 0; v < 4; v++) begin
      bus0.entropy = vecs[v].ent;
      for (int g = 0; g < vecs[v].gap; g++) @(negedge clk);
      bus0.new_game = 1'b1;
      @(negedge clk);
      bus0.new_game = 1'b0;
      checkOutput("fb_busy", 32'(bus0.busy), 32'd1);
      lat0 = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (bus0.answer_valid) begin
          lat0 = k;
          break;
        end
      end
      checkOutput("fb_latency", 32'(lat0), 32'(vecs[v].exp_lat));
      checkOutput("fb_answer", 32'(bus0.answer), 32'(vecs[v].exp_ans));
    end
    bus0.entropy = 1'b0;

    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < int'($urandom_range(5, 0)); i++)
        applyStimulus(1'b0, 1'($urandom_range(1, 0)));
      runGame(0, 1'b1, ans_a);
    end

    doReset();
    runGame(0, 1'b0, ans_a);
    doReset();
    runGame(0, 1'b0, ans_b);
    checkOutput("determinism", 32'(bus.answer), 32'(ans_a));

    runGame(1, 1'b1, ans_a);
    runGame(2, 1'b1, ans_a);

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("mid_draw_reset_answer", 32'(bus.answer), 32'h0);
    checkOutput("mid_draw_reset_valid", 32'(bus.answer_valid), 32'd0);
    checkOutput("mid_draw_reset_busy", 32'(bus.busy), 32'd0);
    model_answer = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    runGame(0, 1'b1, ans_a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
